// File: rtl/fpmac_seq_if.sv
// Handshake and MAC-unit bundle for the FP16 dot-product sequencer.
// The slave modport is the sequencer side; master is the surrounding environment.
interface fpmac_seq_if #(
   parameter int unsigned CW = 8
);
   logic          s_valid;
   logic          s_ready;
   logic [15:0]   s_in;
   logic [15:0]   s_weight;
   logic          s_last;
   logic [15:0]   mac_in;
   logic [15:0]   mac_weight;
   logic [15:0]   mac_acc;
   logic [15:0]   mac_out;
   logic          mac_overflow;
   logic          m_valid;
   logic          m_ready;
   logic [15:0]   m_data;
   logic          m_overflow;
   logic [CW-1:0] m_count;

   modport slave (
      input  s_valid, s_in, s_weight, s_last, mac_out, mac_overflow, m_ready,
      output s_ready, mac_in, mac_weight, mac_acc, m_valid, m_data, m_overflow, m_count
   );

   modport master (
      output s_valid, s_in, s_weight, s_last, mac_out, mac_overflow, m_ready,
      input  s_ready, mac_in, mac_weight, mac_acc, m_valid, m_data, m_overflow, m_count
   );
endinterface

// File: rtl/fpmac_seq.sv
// Sequences FP16 operand pairs through an external fixed-latency MAC, one pair in flight at a time.
// Optional macro FPMAC_SEQ_OVF_STICKY_EN: m_overflow is the OR over all pairs, else the last pair's.
module fpmac_seq #(
   parameter int unsigned LAT = 12,
   parameter int unsigned CW  = 8
) (
   input logic        CLK,
   input logic        RST,
   fpmac_seq_if.slave bus
);
   localparam int unsigned CntW = $clog2(LAT + 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     sum_q, sum_d;
   logic [15:0]     in_q, in_d;
   logic [15:0]     weight_q, weight_d;
   logic [15:0]     acc_q, acc_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            last_q, last_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      last_d   = last_q;
      // MAC operand registers are non-zero only in the single issue cycle.
      in_d     = '0;
      weight_d = '0;
      acc_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (bus.s_valid) begin
               in_d     = bus.s_in;
               weight_d = bus.s_weight;
               acc_d    = sum_q;
               last_d   = bus.s_last;
               cnt_d    = CntW'(LAT);
               state_d  = StWait;
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               sum_d = bus.mac_out;
`ifdef FPMAC_SEQ_OVF_STICKY_EN
               ovf_d = ovf_q | bus.mac_overflow;
`else
               ovf_d = bus.mac_overflow;
`endif
               if (count_q != '1) begin
                  count_d = count_q + CW'(1);
               end
               state_d = last_q ? StDone : StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StDone: begin
            if (bus.m_ready) begin
               sum_d   = '0;
               count_d = '0;
               ovf_d   = 1'b0;
               last_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         sum_q    <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         last_q   <= 1'b0;
         in_q     <= '0;
         weight_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         last_q   <= last_d;
         in_q     <= in_d;
         weight_q <= weight_d;
         acc_q    <= acc_d;
      end
   end

   assign bus.s_ready    = (state_q == StIdle);
   assign bus.m_valid    = (state_q == StDone);
   assign bus.m_data     = sum_q;
   assign bus.m_overflow = ovf_q;
   assign bus.m_count    = count_q;
   assign bus.mac_in     = in_q;
   assign bus.mac_weight = weight_q;
   assign bus.mac_acc    = acc_q;
endmodule

// File: tb/tb_fpmac_seq.sv
// Directed bench for fpmac_seq with a fixed-latency lookup-table MAC model.
module tb_fpmac_seq;
   localparam int unsigned LAT = 12;
   localparam int unsigned CW  = 8;
`ifdef FPMAC_SEQ_OVF_STICKY_EN
   localparam logic ExpOvf = 1'b1;
`else
   localparam logic ExpOvf = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   passes = 0;

   fpmac_seq_if #(.CW(CW)) bus ();

   fpmac_seq #(.LAT(LAT), .CW(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Hand-computed FP16 a*w+c for the vectors used below; {overflow, result}.
   function automatic logic [16:0] mac_model(input logic [15:0] a, input logic [15:0] w,
                                             input logic [15:0] c);
      case ({a, w, c})
         {16'h3C00, 16'h4000, 16'h0000}: return {1'b0, 16'h4000};
         {16'h4200, 16'h3C00, 16'h4000}: return {1'b0, 16'h4500};
         {16'h4000, 16'h4200, 16'h0000}: return {1'b0, 16'h4600};
         {16'h7800, 16'h7800, 16'h0000}: return {1'b1, 16'h7C00};
         {16'h0000, 16'h0000, 16'h7C00}: return {1'b0, 16'h7C00};
         {16'h3C00, 16'h3C00, 16'h0000}: return {1'b0, 16'h3C00};
         default:                        return 17'h0;
      endcase
   endfunction

   logic [16:0] pipe [LAT];
   always @(posedge CLK) begin
      pipe[0] <= mac_model(bus.mac_in, bus.mac_weight, bus.mac_acc);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.mac_out      = pipe[LAT-1][15:0];
   assign bus.mac_overflow = pipe[LAT-1][16];

   task automatic issue_pair(input string name, input logic [15:0] a, input logic [15:0] w,
                             input logic last, input logic [15:0] exp_acc);
      int n = 0;
      bus.s_in = a; bus.s_weight = w; bus.s_last = last; bus.s_valid = 1'b1;
      while (bus.s_ready !== 1'b1 && n < 100) begin
         @(posedge CLK); #1; n++;
      end
      if (n >= 100) begin
         checks++;
         $display("FAIL %s_ready_timeout: s_ready=%b after %0d cycles, want 1", name, bus.s_ready, n);
         bus.s_valid = 1'b0;
         return;
      end
      @(posedge CLK); #1;
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
      checks++;
      if (bus.mac_in !== a) $display("FAIL %s_mac_in: got %h want %h", name, bus.mac_in, a);
      else passes++;
      checks++;
      if (bus.mac_weight !== w) $display("FAIL %s_mac_weight: got %h want %h", name, bus.mac_weight, w);
      else passes++;
      checks++;
      if (bus.mac_acc !== exp_acc) $display("FAIL %s_mac_acc: got %h want %h", name, bus.mac_acc, exp_acc);
      else passes++;
      checks++;
      if (bus.s_ready !== 1'b0) $display("FAIL %s_issue_s_ready: got %b want 0", name, bus.s_ready);
      else passes++;
   endtask

   // Remaining LAT wait cycles must hold s_ready low with idle MAC operands.
   task automatic wait_pair_done(input string name, input logic last);
      int bad = 0;
      for (int i = 0; i < int'(LAT); i++) begin
         @(posedge CLK); #1;
         if (bus.s_ready !== 1'b0 || bus.mac_in !== 16'h0 || bus.mac_weight !== 16'h0 ||
             bus.mac_acc !== 16'h0) bad++;
      end
      checks++;
      if (bus.s_ready !== 1'b0 && bad == 0) bad = 0;
      if (bad != 0) $display("FAIL %s_wait: %0d bad cycles, want 0", name, bad);
      else passes++;
      @(posedge CLK); #1;
      checks++;
      if (bus.s_ready !== !last) $display("FAIL %s_after_wait_s_ready: got %b want %b", name, bus.s_ready, !last);
      else passes++;
      checks++;
      if (bus.m_valid !== last) $display("FAIL %s_after_wait_m_valid: got %b want %b", name, bus.m_valid, last);
      else passes++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      checks++;
      if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); else passes++;
      checks++;
      if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else passes++;
      checks++;
      if (bus.mac_in !== 16'h0) $display("FAIL reset_mac_in: got %h want 0000", bus.mac_in); else passes++;
      checks++;
      if (bus.mac_weight !== 16'h0) $display("FAIL reset_mac_weight: got %h want 0000", bus.mac_weight);
      else passes++;
      checks++;
      if (bus.mac_acc !== 16'h0) $display("FAIL reset_mac_acc: got %h want 0000", bus.mac_acc); else passes++;
      checks++;
      if (bus.m_count !== 8'd0) $display("FAIL reset_m_count: got %0d want 0", bus.m_count); else passes++;
      RST = 1'b0;
   endtask

   task automatic test_two_pair();
      issue_pair("tp1", 16'h3C00, 16'h4000, 1'b0, 16'h0000);
      // Next pair offered during WAIT must be held off, not issued early.
      bus.s_in = 16'h4200; bus.s_weight = 16'h3C00; bus.s_last = 1'b1; bus.s_valid = 1'b1;
      wait_pair_done("tp1", 1'b0);
      issue_pair("tp2", 16'h4200, 16'h3C00, 1'b1, 16'h4000);
      wait_pair_done("tp2", 1'b1);
      checks++;
      if (bus.m_data !== 16'h4500) $display("FAIL tp_m_data: got %h want 4500", bus.m_data); else passes++;
      checks++;
      if (bus.m_count !== 8'd2) $display("FAIL tp_m_count: got %0d want 2", bus.m_count); else passes++;
      checks++;
      if (bus.m_overflow !== 1'b0) $display("FAIL tp_m_overflow: got %b want 0", bus.m_overflow); else passes++;
   endtask

   task automatic test_backpressure();
      int bad = 0;
      bus.m_ready = 1'b0;
      bus.s_in = 16'h4000; bus.s_weight = 16'h4200; bus.s_last = 1'b1; bus.s_valid = 1'b1;
      repeat (20) begin
         @(posedge CLK); #1;
         if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h4500 || bus.m_count !== 8'd2 ||
             bus.s_ready !== 1'b0 || bus.mac_in !== 16'h0) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); else passes++;
      bus.m_ready = 1'b1;
      @(posedge CLK); #1;
      bus.m_ready = 1'b0;
      checks++;
      if (bus.m_valid !== 1'b0) $display("FAIL bp_release_m_valid: got %b want 0", bus.m_valid); else passes++;
      checks++;
      if (bus.s_ready !== 1'b1) $display("FAIL bp_release_s_ready: got %b want 1", bus.s_ready); else passes++;
      checks++;
      if (bus.m_count !== 8'd0) $display("FAIL bp_release_m_count: got %0d want 0", bus.m_count); else passes++;
   endtask

   task automatic test_single();
      issue_pair("sg", 16'h4000, 16'h4200, 1'b1, 16'h0000);
      wait_pair_done("sg", 1'b1);
      checks++;
      if (bus.m_data !== 16'h4600) $display("FAIL sg_m_data: got %h want 4600", bus.m_data); else passes++;
      checks++;
      if (bus.m_count !== 8'd1) $display("FAIL sg_m_count: got %0d want 1", bus.m_count); else passes++;
      bus.m_ready = 1'b1;
      @(posedge CLK); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_overflow();
      issue_pair("ov1", 16'h7800, 16'h7800, 1'b0, 16'h0000);
      wait_pair_done("ov1", 1'b0);
      issue_pair("ov2", 16'h0000, 16'h0000, 1'b1, 16'h7C00);
      wait_pair_done("ov2", 1'b1);
      checks++;
      if (bus.m_data !== 16'h7C00) $display("FAIL ov_m_data: got %h want 7c00", bus.m_data); else passes++;
      checks++;
      if (bus.m_count !== 8'd2) $display("FAIL ov_m_count: got %0d want 2", bus.m_count); else passes++;
      checks++;
      if (bus.m_overflow !== ExpOvf) $display("FAIL ov_m_overflow: got %b want %b", bus.m_overflow, ExpOvf);
      else passes++;
      bus.m_ready = 1'b1;
      @(posedge CLK); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      issue_pair("rw1", 16'h3C00, 16'h4000, 1'b0, 16'h0000);
      wait_pair_done("rw1", 1'b0);
      issue_pair("rw2", 16'h4200, 16'h3C00, 1'b1, 16'h4000);
      repeat (5) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++;
      if (bus.s_ready !== 1'b1) $display("FAIL rw_s_ready: got %b want 1", bus.s_ready); else passes++;
      checks++;
      if (bus.m_valid !== 1'b0) $display("FAIL rw_m_valid: got %b want 0", bus.m_valid); else passes++;
      checks++;
      if (bus.m_count !== 8'd0) $display("FAIL rw_m_count: got %0d want 0", bus.m_count); else passes++;
      // Let the aborted result drain out of the MAC while idle.
      repeat (LAT) @(posedge CLK);
      #1;
      checks++;
      if (bus.m_data !== 16'h0000) $display("FAIL rw_stale_m_data: got %h want 0000", bus.m_data); else passes++;
      issue_pair("rw3", 16'h3C00, 16'h3C00, 1'b1, 16'h0000);
      wait_pair_done("rw3", 1'b1);
      checks++;
      if (bus.m_data !== 16'h3C00) $display("FAIL rw3_m_data: got %h want 3c00", bus.m_data); else passes++;
      checks++;
      if (bus.m_count !== 8'd1) $display("FAIL rw3_m_count: got %0d want 1", bus.m_count); else passes++;
      bus.m_ready = 1'b1;
      @(posedge CLK); #1;
      bus.m_ready = 1'b0;
   endtask

   initial begin
      bus.s_valid  = 1'b0;
      bus.s_in     = 16'h0;
      bus.s_weight = 16'h0;
      bus.s_last   = 1'b0;
      bus.m_ready  = 1'b0;
      test_reset();
      test_two_pair();
      test_backpressure();
      test_single();
      test_overflow();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
